// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth recoding pairs Q[1:0]: 01 adds M, 10 subtracts M, 00/11 only shift.
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SUB = 2'b10;

    // Step counter must hold 0..WIDTH (WIDTH+1 steps).
    function automatic int cnt_w(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_r2_step.sv
// One combinational radix-2 Booth step: conditional add/subtract of M into A,
// then arithmetic right shift of the combined {A,Q}.
module booth_r2_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH+1:0] a_i,
    input  logic [WIDTH+1:0] q_i,
    input  logic [WIDTH:0]   m_i,
    output logic [WIDTH+1:0] a_o,
    output logic [WIDTH+1:0] q_o
);
    localparam int AW = WIDTH + 2;

    logic [AW-1:0] m_ext;
    logic [AW-1:0] sum;

    assign m_ext = {m_i[WIDTH], m_i};

    always_comb begin
        sum = a_i;
        case (q_i[1:0])
            ADD:     sum = a_i + m_ext;
            SUB:     sum = a_i + ~m_ext + AW'(1);
            default: sum = a_i;
        endcase
    end

    // The bit shifted out of A enters the top of Q; A keeps its sign.
    assign a_o = {sum[AW-1], sum[AW-1:1]};
    assign q_o = {sum[0], q_i[AW-1:1]};

endmodule

// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation,
// with a start/busy/done handshake and a product register updated only on completion.
module booth_mult_param
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               St,
    input  logic               Sgn,
    input  logic [WIDTH-1:0]   Mplier,
    input  logic [WIDTH-1:0]   Mcand,
    output logic [2*WIDTH-1:0] Product,
    output logic               Busy,
    output logic               Done
);
    localparam int            CW        = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH+1:0]   a_q, a_d;
    logic [WIDTH+1:0]   q_q, q_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH+1:0]   a_step;
    logic [WIDTH+1:0]   q_step;

    booth_r2_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .m_i (m_q),
        .a_o (a_step),
        .q_o (q_step)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (St) begin
                    // Operands are captured here so the inputs may change during RUN.
                    state_d = RUN;
                    m_d     = {Sgn & Mcand[WIDTH-1], Mcand};
                    q_d     = {Sgn & Mplier[WIDTH-1], Mplier, 1'b0};
                    a_d     = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d   = a_step;
                q_d   = q_step;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    // Low 2*WIDTH bits of {A, Q[WIDTH+1:1]} after the final shift.
                    state_d   = DONE;
                    product_d = {a_step[WIDTH-2:0], q_step[WIDTH+1:1]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Product = product_q;
    assign Busy    = (state_q == RUN);
    assign Done    = (state_q == DONE);

endmodule

// File: tb/tb_booth_mult_param.sv
// Bench for booth_mult_param: WIDTH=8 instance checked through a scoreboard,
// WIDTH=16 instance checked by direct start/wait sequences.
module tb_booth_mult_param;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;

    logic        St8 = 1'b0, Sgn8 = 1'b0;
    logic [7:0]  Mplier8 = '0, Mcand8 = '0;
    logic [15:0] Product8;
    logic        Busy8, Done8;

    logic        St16 = 1'b0, Sgn16 = 1'b0;
    logic [15:0] Mplier16 = '0, Mcand16 = '0;
    logic [31:0] Product16;
    logic        Busy16, Done16;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_txn = 0;

    typedef struct {
        logic [15:0] prod;
        int          start;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic        sgn;
        logic [7:0]  mp;
        logic [7:0]  mc;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs[10];

    booth_mult_param #(.WIDTH(8)) u_dut8 (
        .Clk     (Clk),
        .Rst     (Rst),
        .St      (St8),
        .Sgn     (Sgn8),
        .Mplier  (Mplier8),
        .Mcand   (Mcand8),
        .Product (Product8),
        .Busy    (Busy8),
        .Done    (Done8)
    );

    booth_mult_param #(.WIDTH(16)) u_dut16 (
        .Clk     (Clk),
        .Rst     (Rst),
        .St      (St16),
        .Sgn     (Sgn16),
        .Mplier  (Mplier16),
        .Mcand   (Mcand16),
        .Product (Product16),
        .Busy    (Busy16),
        .Done    (Done16)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
        logic signed [63:0] sa;
        logic signed [63:0] sb_v;
        for (int i = 0; i < 64; i++) begin
            sa[i]   = (i < w) ? a[i] : (s & a[w-1]);
            sb_v[i] = (i < w) ? b[i] : (s & b[w-1]);
        end
        return sa * sb_v;
    endfunction

    // Scoreboard monitor for the WIDTH=8 instance.
    logic        rst_edge  = 1'b1;
    logic [15:0] prod_prev = '0;
    always @(posedge Clk) rst_edge <= Rst;

    always @(negedge Clk) begin
        if (Done8) begin
            if (sb.size() == 0) begin
                chk("unexpected_done8", 64'(Done8), 64'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                n_txn++;
                $display("txn %0d: product=0x%04h expected=0x%04h latency=%0d",
                         n_txn, Product8, e.prod, cyc - e.start);
                chk("product8", 64'(Product8), 64'(e.prod));
                chk("latency8", 64'(cyc - e.start), 64'd9);
            end
        end
        if (!rst_edge && Product8 !== prod_prev)
            chk("product8_changed_without_done", 64'(Done8), 64'd1);
        prod_prev = Product8;
    end

    task automatic start8(input logic s, input logic [7:0] mp, input logic [7:0] mc,
                          input logic [15:0] e, input bit push);
        sb_t t;
        @(posedge Clk); #1;
        St8 = 1'b1; Sgn8 = s; Mplier8 = mp; Mcand8 = mc;
        if (push) begin
            t.prod  = e;
            t.start = cyc + 1;
            sb.push_back(t);
        end
        @(posedge Clk); #1;
        // Operands are scrambled right after the start edge; the result must not care.
        St8 = 1'b0; Sgn8 = 1'($urandom); Mplier8 = 8'($urandom); Mcand8 = 8'($urandom);
    endtask

    task automatic wait_done8();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge Clk);
            if (Done8) seen = 1'b1;
        end
        if (!seen) chk("done8_timeout", 64'd0, 64'd1);
    endtask

    task automatic run16(input logic s, input logic [15:0] mp, input logic [15:0] mc,
                         input logic [31:0] e);
        int  t0;
        bit  seen = 1'b0;
        @(posedge Clk); #1;
        St16 = 1'b1; Sgn16 = s; Mplier16 = mp; Mcand16 = mc;
        t0 = cyc + 1;
        @(posedge Clk); #1;
        St16 = 1'b0; Mplier16 = 16'($urandom); Mcand16 = 16'($urandom);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge Clk);
            if (Done16) seen = 1'b1;
        end
        if (!seen) begin
            chk("done16_timeout", 64'd0, 64'd1);
        end else begin
            n_txn++;
            $display("txn %0d: w16 product=0x%08h expected=0x%08h latency=%0d",
                     n_txn, Product16, e, cyc - t0);
            chk("product16", 64'(Product16), 64'(e));
            chk("latency16", 64'(cyc - t0), 64'd17);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        s;
        logic [7:0]  a8, b8;
        logic [15:0] a16, b16;
        bit          any_done;

        vecs[0] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[1] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[2] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[3] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[4] = '{1'b1, 8'h05, 8'hFD, 16'hFFF1};
        vecs[5] = '{1'b0, 8'h80, 8'h02, 16'h0100};
        vecs[6] = '{1'b0, 8'h00, 8'hAB, 16'h0000};
        vecs[7] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[8] = '{1'b0, 8'h12, 8'h34, 16'h03A8};
        vecs[9] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};

        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        chk("reset_product", 64'(Product8), 64'd0);
        chk("reset_busy", 64'(Busy8), 64'd0);
        chk("reset_done", 64'(Done8), 64'd0);
        chk("reset_product16", 64'(Product16), 64'd0);

        for (int i = 0; i < 10; i++) begin
            start8(vecs[i].sgn, vecs[i].mp, vecs[i].mc, vecs[i].exp, 1'b1);
            wait_done8();
        end

        // A start pulse mid-RUN is ignored; St held in DONE restarts at once.
        start8(1'b0, 8'd3, 8'd5, 16'h000F, 1'b1);
        repeat (2) @(posedge Clk);
        #1;
        chk("busy_mid_run", 64'(Busy8), 64'd1);
        St8 = 1'b1; Sgn8 = 1'b0; Mplier8 = 8'd7; Mcand8 = 8'd7;
        @(posedge Clk); #1;
        St8 = 1'b0;
        wait_done8();
        chk("busy_in_done", 64'(Busy8), 64'd0);
        St8 = 1'b1; Sgn8 = 1'b0; Mplier8 = 8'd2; Mcand8 = 8'd2;
        begin
            sb_t t;
            t.prod  = 16'h0004;
            t.start = cyc + 1;
            sb.push_back(t);
        end
        @(posedge Clk); #1;
        St8 = 1'b0; Mcand8 = 8'hA5; Mplier8 = 8'h5A;
        chk("busy_after_b2b_start", 64'(Busy8), 64'd1);
        wait_done8();

        // Reset at RUN step 4 aborts with no Done and clears Product.
        start8(1'b0, 8'h55, 8'h11, 16'h0000, 1'b0);
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        chk("abort_busy", 64'(Busy8), 64'd0);
        chk("abort_done", 64'(Done8), 64'd0);
        chk("abort_product", 64'(Product8), 64'd0);
        any_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (Done8) any_done = 1'b1;
        end
        chk("abort_no_done", 64'(any_done), 64'd0);
        start8(1'b0, 8'h12, 8'h34, 16'h03A8, 1'b1);
        wait_done8();

        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 300; i++) begin
                s  = 1'(m);
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                start8(s, a8, b8, 16'(ref_mul(s, 32'(a8), 32'(b8), 8)), 1'b1);
                wait_done8();
            end
        end

        run16(1'b1, 16'h7FFF, 16'h8000, 32'hC0008000);
        run16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 50; i++) begin
                s   = 1'(m);
                a16 = 16'($urandom);
                b16 = 16'($urandom);
                run16(s, a16, b16, 32'(ref_mul(s, 32'(a16), 32'(b16), 16)));
            end
        end

        repeat (3) @(negedge Clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/booth_mult_param.md
# booth_mult_param

Parametrised sequential radix-2 Booth multiplier, the next generation of the team's 8-bit shift-add Booth multiplier. It multiplies two WIDTH-bit operands as either signed (two's complement) or unsigned, selected per operation. It performs one combined add-and-shift step per clock, so latency is fixed. It sits behind a simple start/busy/done handshake in the datapath. Product is registered and changes only on completion.

## Interface
- WIDTH, 8: operand width; legal range 4..32.
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- St  in  1  start request; sampled only in IDLE or DONE.
- Sgn  in  1  1 = signed operands, 0 = unsigned; sampled with St.
- Mplier  in  WIDTH  multiplier; sampled with St.
- Mcand  in  WIDTH  multiplicand; sampled with St and held internally, so the input may change after the start.
- Product  out  2*WIDTH  result register; holds the last result until the next completion.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse, high in DONE.

## Operation
- States:
  - IDLE: St=1 → RUN.
  - RUN: stays in RUN until the step counter reaches WIDTH, then → DONE.
  - DONE: St=1 → RUN; otherwise → IDLE.
- Start actions, taken on the start edge:
  - Extend Mcand to WIDTH+1 bits. The extension bit is Mcand[WIDTH-1] if Sgn=1, else 0. Store the result as M.
  - Load multiplier register Q (WIDTH+2 bits) = {ext(Mplier), 1'b0}.
  - Clear accumulator A (WIDTH+2 bits).
  - Clear step counter. It is $clog2(WIDTH+2) bits wide.
- RUN step, one per cycle, based on the pair Q[1:0]:
  - 01: A+ext(M).
  - 10: A−ext(M), implemented as A + ~ext(M) + 1.
  - 00/11: A unchanged.
  - Then arithmetic-shift the combined {A,Q} right by one.
  - The counter increments each step.
- Step count is WIDTH+1. The extra step covers the extension bit, so unsigned operands with MSB=1 are correct.
- On the final RUN step, load Product with the low 2*WIDTH bits of the {A, Q[WIDTH+1:1]} result after the shift.
- Arithmetic:
  - All additions are WIDTH+2 bits, modulo 2^(WIDTH+2).
  - No overflow is possible: the full signed or unsigned product fits in 2*WIDTH bits.
- St, Sgn and operand changes during RUN are ignored; no queuing.

## Timing
- St=1 sampled at edge k (IDLE or DONE): Busy=1 from edge k through edge k+WIDTH+1.
- RUN steps occur at edges k+1 .. k+WIDTH+1.
- At edge k+WIDTH+1: Product updated, Done=1, Busy=0. Done lasts exactly one cycle.
- Latency from St to Done is WIDTH+1 cycles (9 for WIDTH=8).
- Back-to-back: St=1 while Done=1 starts the next operation at that same edge. Throughput is one result per WIDTH+1 cycles.
- Reset values: state IDLE, Product=0, Busy=0, Done=0, A=0, Q=0, M=0, counter=0.
- Rst has priority over St at any edge. Rst mid-RUN aborts the operation: no Done, and Product is cleared to 0.
- Product is stable between completions. Partial results are never visible on Product.

## Structure
- Package booth_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - function cnt_w(WIDTH) = $clog2(WIDTH+2);
  - Booth pair constants (ADD=2'b01, SUB=2'b10).
- Sub-module booth_r2_step is purely combinational:
  - inputs: A, Q, M;
  - outputs: next A and next Q (add/subtract + arithmetic shift), parametrised by WIDTH.
- The top level holds the FSM, counter, operand and product registers.

## Test plan
- WIDTH=8, Sgn=1:
  - Mplier=0x80, Mcand=0x80 (−128×−128) → Product=0x4000; Done at cycle 9 after St.
  - Mplier=0xFF, Mcand=0x01 → Product=0xFFFF.
- WIDTH=8, Sgn=0, Mplier=0xFF, Mcand=0xFF (255×255) → Product=0xFE01.
- WIDTH=16, Sgn=1, Mplier=0x7FFF, Mcand=0x8000 → Product=0xC0008000; Done 17 cycles after St.
- Start with 3×5 (Sgn=0). Pulse St with 7×7 mid-RUN → ignored; Product=0x000F.
  - St held during DONE with 2×2 → second result 0x0004 exactly 9 cycles later.
  - Mcand changed the cycle after St → result unaffected.
- Assert Rst at RUN step 4 → Busy=0, Done never pulses, Product=0.
  - The next start with 0x12×0x34 (unsigned) → 0x03A8.
- Random regression: 10k operands per mode for WIDTH ∈ {4, 8, 13, 32}, checked against a behavioural multiply.
